// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and constants for the decode hazard controller.
package decode_hazard_ctrl_pkg;

  localparam int unsigned NREG  = 16;
  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  // Decode latch / fetch control bundle.
  typedef struct packed {
    logic if_stall;
    logic latch_en;
    logic bubble;
    logic if_flush;
  } ctrl_t;

  // NOP controls: latch loads a bubble, fetch runs freely.
  localparam ctrl_t CTRL_NOP = '{if_stall: 1'b0, latch_en: 1'b1, bubble: 1'b1, if_flush: 1'b0};

  // One-hot register mask for a register index.
  function automatic logic [NREG-1:0] reg_mask(input logic [REG_W-1:0] idx);
    return NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_scoreboard.sv
// In-flight destination scoreboard with WB-to-decode bypass on the read ports.
module decode_hazard_ctrl_scoreboard
  import decode_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_idx,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_idx,
  input  logic [REG_W-1:0] i_rs_a,
  input  logic [REG_W-1:0] i_rs_b,
  output logic             o_busy_a,
  output logic             o_busy_b,
  output logic [NREG-1:0]  o_busy_vec
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_eff;

  assign w_set_mask = i_set_en ? reg_mask(i_set_idx) : '0;
  assign w_clr_mask = i_clr_en ? reg_mask(i_clr_idx) : '0;
  // A register retiring this cycle is already readable by decode.
  assign w_busy_eff = r_busy & ~w_clr_mask;

  assign o_busy_a   = w_busy_eff[i_rs_a];
  assign o_busy_b   = w_busy_eff[i_rs_b];
  assign o_busy_vec = r_busy;

  // Set beats clear on the same index; r0 never becomes busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
    end
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode latch sequencer: RAW stall, branch wait and taken-branch flush.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_writes_rd,
  input  logic             id_is_branch,
  input  logic             ex_br_resolve,
  input  logic             ex_br_taken,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  output logic             if_stall,
  output logic             id_latch_en,
  output logic             id_bubble,
  output logic             if_flush,
  output logic [NREG-1:0]  busy_vec
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  ctrl_t            w_ctrl;
  logic             w_busy_a;
  logic             w_busy_b;
  logic             w_raw;
  logic             w_issue;
  logic             w_set_en;

  decode_hazard_ctrl_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_set_en),
    .i_set_idx  (id_rd),
    .i_clr_en   (wb_valid),
    .i_clr_idx  (wb_rd),
    .i_rs_a     (id_rs_a),
    .i_rs_b     (id_rs_b),
    .o_busy_a   (w_busy_a),
    .o_busy_b   (w_busy_b),
    .o_busy_vec (busy_vec)
  );

  assign w_raw    = id_valid & ((id_uses_a & w_busy_a) | (id_uses_b & w_busy_b));
  assign w_issue  = w_ctrl.latch_en & ~w_ctrl.bubble;
  assign w_set_en = w_issue & id_writes_rd & (id_rd != '0);

  // State and flush counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state and latch/fetch control decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ctrl       = CTRL_NOP;
    case (r_state)
      ST_RUN: begin
        if (w_raw) begin
          w_ctrl.if_stall = 1'b1;
        end else if (id_valid) begin
          w_ctrl.bubble = 1'b0;
          if (id_is_branch) w_state_next = ST_BR_WAIT;
        end
      end
      ST_BR_WAIT: begin
        if (ex_br_resolve && ex_br_taken) begin
          w_ctrl.if_flush = 1'b1;
          w_cnt_next      = CNT_W'(FLUSH_CYCLES - 1);
          w_state_next    = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else begin
          // Not-taken resolve frees the branch slot for the instruction in decode now.
          if (ex_br_resolve) w_state_next = ST_RUN;
          if (w_raw || (id_valid && id_is_branch && !ex_br_resolve)) begin
            w_ctrl.if_stall = 1'b1;
          end else if (id_valid) begin
            w_ctrl.bubble = 1'b0;
            if (id_is_branch) w_state_next = ST_BR_WAIT;
          end
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) w_state_next = ST_RUN;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      default: w_state_next = ST_RUN;
    endcase
    // Reset forces NOP controls asynchronously.
    if (rst) w_ctrl = CTRL_NOP;
  end

  assign if_stall    = w_ctrl.if_stall;
  assign id_latch_en = w_ctrl.latch_en;
  assign id_bubble   = w_ctrl.bubble;
  assign if_flush    = w_ctrl.if_flush;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: directed scenarios plus random traffic vs a model.
module tb_decode_hazard_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs_a;
  logic [3:0]  id_rs_b;
  logic        id_uses_a;
  logic        id_uses_b;
  logic [3:0]  id_rd;
  logic        id_writes_rd;
  logic        id_is_branch;
  logic        ex_br_resolve;
  logic        ex_br_taken;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        if_stall;
  logic        id_latch_en;
  logic        id_bubble;
  logic        if_flush;
  logic [15:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: busy set, one outstanding-branch flag, remaining forced bubbles.
  logic [15:0] m_busy;
  bit          m_br_out;
  int          m_bubbles_left;

  decode_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs_a       (id_rs_a),
    .id_rs_b       (id_rs_b),
    .id_uses_a     (id_uses_a),
    .id_uses_b     (id_uses_b),
    .id_rd         (id_rd),
    .id_writes_rd  (id_writes_rd),
    .id_is_branch  (id_is_branch),
    .ex_br_resolve (ex_br_resolve),
    .ex_br_taken   (ex_br_taken),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .if_stall      (if_stall),
    .id_latch_en   (id_latch_en),
    .id_bubble     (id_bubble),
    .if_flush      (if_flush),
    .busy_vec      (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs_a = 0; id_rs_b = 0; id_uses_a = 0; id_uses_b = 0;
    id_rd = 0; id_writes_rd = 0; id_is_branch = 0;
    ex_br_resolve = 0; ex_br_taken = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_br_out = 0;
    m_bubbles_left = 0;
  endtask

  // Reset asserted between clock edges; outputs must follow at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_stall",  32'(if_stall),    32'd0);
    check_eq("rst_lat_en", 32'(id_latch_en), 32'd1);
    check_eq("rst_bubble", 32'(id_bubble),   32'd1);
    check_eq("rst_flush",  32'(if_flush),    32'd0);
    check_eq("rst_busy",   32'(busy_vec),    32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic cyc(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                     input logic ua, input logic ub, input logic [3:0] rd, input logic wr,
                     input logic br, input logic res, input logic tkn,
                     input logic wbv, input logic [3:0] wbr);
    logic [15:0] clr, eff;
    bit raw, blocked, issue, e_stall, e_bubble, e_flush;
    @(negedge clk);
    id_valid = v; id_rs_a = ra; id_rs_b = rb; id_uses_a = ua; id_uses_b = ub;
    id_rd = rd; id_writes_rd = wr; id_is_branch = br;
    ex_br_resolve = res; ex_br_taken = tkn; wb_valid = wbv; wb_rd = wbr;
    #1;
    clr = wbv ? (16'(1) << wbr) : 16'h0;
    eff = m_busy & ~clr;
    raw = v && ((ua && eff[ra]) || (ub && eff[rb]));
    e_stall = 0; e_bubble = 1; e_flush = 0; issue = 0;
    if (m_bubbles_left > 0) begin
      m_bubbles_left--;
    end else if (m_br_out && res && tkn) begin
      e_flush = 1;
      m_br_out = 0;
      m_bubbles_left = (FC == 1) ? 0 : FC;
    end else begin
      blocked = raw || (m_br_out && !res && v && br);
      e_stall = blocked;
      issue = v && !blocked;
      e_bubble = !issue;
      if (res) m_br_out = 0;
      if (issue && br) m_br_out = 1;
    end
    check_eq("if_stall",    32'(if_stall),    32'(e_stall));
    check_eq("id_latch_en", 32'(id_latch_en), 32'd1);
    check_eq("id_bubble",   32'(id_bubble),   32'(e_bubble));
    check_eq("if_flush",    32'(if_flush),    32'(e_flush));
    check_eq("busy_vec",    32'(busy_vec),    32'(m_busy));
    m_busy = m_busy & ~clr;
    if (issue && wr && rd != 4'd0) m_busy = m_busy | (16'(1) << rd);
  endtask

  initial begin
    int stalls;
    int bubbles;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    id_valid = 1'b1;
    #1;
    check_eq("init_bubble",  32'(id_bubble),   32'd1);
    check_eq("init_lat_en",  32'(id_latch_en), 32'd1);
    check_eq("init_stall",   32'(if_stall),    32'd0);
    check_eq("init_busy",    32'(busy_vec),    32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    // RAW stall released in the WB cycle.
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    check_eq("t2_issue_bubble", 32'(id_bubble), 32'd0);
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 3, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0);
      if (if_stall && id_bubble) stalls++;
    end
    cyc(1, 3, 1, 1, 0, 4, 1, 0, 0, 0, 1, 3);
    check_eq("t2_stall_cycles", 32'(stalls), 32'd2);
    check_eq("t2_release_stall", 32'(if_stall), 32'd0);
    check_eq("t2_release_issue", 32'(id_bubble), 32'd0);

    // Reset while a consumer is stalled on r3.
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 4);
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_pre_stall", 32'(if_stall), 32'd1);
    do_reset();
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_post_stall", 32'(if_stall), 32'd0);

    // Writes to r0 never mark anything busy.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    check_eq("t3_r0_stall", 32'(if_stall), 32'd0);
    check_eq("t3_r0_busy",  32'(busy_vec), 32'd0);

    // Same-cycle clear and set of r5: set wins.
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_busy5", 32'(busy_vec[5]), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);

    // Taken branch: one flush pulse, three bubbles, no wrong-path scoreboard bits.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bubbles = 0;
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 1, 1, 0, 0);
    check_eq("t5_flush", 32'(if_flush), 32'd1);
    if (id_bubble) bubbles++;
    cyc(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    check_eq("t5_flush_once", 32'(if_flush), 32'd0);
    if (id_bubble) bubbles++;
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    if (id_bubble) bubbles++;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_bubbles", 32'(bubbles), 32'd3);
    check_eq("t5_back_run", 32'(id_bubble), 32'd0);
    check_eq("t5_no_wrong_busy", 32'(busy_vec), 32'd0);

    // Second branch waits for a not-taken resolve, then issues.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check_eq("t6_hold", 32'(if_stall), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    check_eq("t6_issue_stall", 32'(if_stall), 32'd0);
    check_eq("t6_issue_bubble", 32'(id_bubble), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check_eq("t6_br_wait_again", 32'(if_stall), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Random traffic over a small register window to provoke hazards.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc($urandom_range(0, 9) < 8,
          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 6) == 0,
          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
